c432_key_loader: RTL and testbench
==================================

# c432_key_loader

Serial key-provisioning unit that loads the 7-bit unlock key for the logic-locked c432 netlist. It accepts a framed, parity-protected bit stream over a valid/ready handshake, verifies it, and commits the key to a parallel register. The register drives the locked core's key inputs: mux-lock keys p1..p4 and XOR-lock keys X_1..X_3. Until a good frame commits, the key register holds zero, so the core runs with a wrong key.

## Interface

**Parameters**
- KEY_W, 7: key width. Bits [3:0] map to p1..p4; bits [6:4] map to X_1..X_3.
- TO_CYC, 16: maximum idle cycles allowed between accepted bits inside a frame.

**Ports**
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- load_start, input, 1: one-cycle pulse that opens a frame. Honoured only in IDLE.
- s_data, input, 1: serial key or parity bit.
- s_valid, input, 1: s_data is valid.
- s_ready, output, 1: loader accepts a bit this cycle.
- zeroize, input, 1: clears the key and aborts any frame. Highest priority after reset.
- key_out, output, KEY_W: committed key, driven to the locked core.
- key_valid, output, 1: key_out holds a verified key.
- busy, output, 1: a frame is in progress.
- err_code, output, 2: result of the last frame. 00 = none/ok, 01 = parity fail, 10 = timeout. Sticky until the next load_start is accepted.

## Operation

**States**
- IDLE: busy=0, s_ready=0.
  - load_start=1 → SHIFT.
  - On the same edge: bit counter cleared, timeout counter cleared, err_code cleared to 00.
- SHIFT: busy=1, s_ready=1.
  - Each s_valid&s_ready edge shifts s_data into the shadow register, LSB first (first bit → shadow[0]).
  - After the KEY_W-th accepted bit → PARITY.
- PARITY: busy=1, s_ready=1.
  - The accepted bit is even parity: XOR(shadow) ^ s_data must equal 0.
  - Pass: key_out ← shadow and key_valid ← 1 on the accepting edge, → IDLE.
  - Fail: err_code ← 01, key_out and key_valid unchanged, → IDLE.

**Timeout**
- In SHIFT/PARITY, the counter increments every cycle without an accepted bit and clears on each accepted bit.
- When it reaches TO_CYC: → IDLE, err_code ← 10, key unchanged, shadow discarded.

**Zeroize**
- On any edge where zeroize=1: key_out ← 0, key_valid ← 0, state → IDLE.
- err_code is unchanged.
- It overrides a simultaneous parity commit and a simultaneous load_start.

**Boundary rules**
- load_start during SHIFT/PARITY is ignored; the frame continues.
- s_valid in IDLE is ignored and not consumed.
- A new good frame replaces the old key atomically. key_out never shows a partial key; the shadow register is separate.
- A failed or timed-out frame leaves the previous good key active.
- Bit counter width is clog2(KEY_W+1) and it never wraps inside a frame.

**Reset values**
- key_out=0, key_valid=0, busy=0, s_ready=0, err_code=00.
- State IDLE; shadow register and counters cleared.
- Reset mid-frame discards all progress, including any previously committed key.

## Timing

- s_ready and busy are registered state decodes. They rise the cycle after the load_start edge and fall the cycle after the parity or timeout edge.
- Minimum frame: 1 start cycle + KEY_W + 1 bit cycles = 9 cycles at KEY_W=7.
  - key_out and key_valid change on the edge that accepts the parity bit.
  - They are visible in the following cycle.
- Back-to-back frames: load_start is accepted in the cycle right after busy falls.
- Timeout fires on the edge where the idle count reaches TO_CYC, i.e. after TO_CYC consecutive cycles with no accepted bit.
- err_code updates on the same edge as the failing parity bit or the timeout.

## Test plan

- **Good load:** load_start, then bits 1,1,0,0,1,0,1 and parity 0, s_valid held high → key_out=7'h53 and key_valid=1 in cycle 9. Core sees p1..p4=1,1,0,0 and X_1..X_3=1,0,1. err_code=00.
- **Parity fail:** after the good load, send bits for 7'h2A with parity 0 (the correct parity is 1) → err_code=01, key_out stays 7'h53, key_valid stays 1.
- **Timeout:** with TO_CYC=16, send 3 bits and then hold s_valid=0 → after 16 cycles busy=0 and err_code=10, key unchanged. A subsequent good frame for 7'h7F with parity 1 → key_out=7'h7F and err_code=00.
- **Sparse handshake:** s_valid toggled 1/0 across all bits (gaps < 16) → same result as the good load, with the frame lasting 17 cycles.
- **Zeroize collision:** zeroize asserted on the same edge as a correct parity bit → key_out=0, key_valid=0, IDLE. A load_start during SHIFT is ignored, with the frame completing normally.
- **Reset mid-frame:** rst_n pulsed low after 4 bits, asynchronously between edges → all outputs return to reset values immediately. The next full frame loads correctly.

Source files
------------

// File: rtl/c432_key_loader.sv
// ---------------------------------------------------------------------------
// c432_key_loader
//
// Serial key-provisioning unit for the logic-locked c432 netlist. A frame is
// opened by load_start. It then carries KEY_W key bits, LSB first, followed by
// one even-parity bit, all over a valid/ready handshake. Bits are collected in
// a shadow register. The parallel key register is written only when the parity
// bit checks out, so the locked core never sees a partial or corrupt key.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   load_start : one-cycle pulse that opens a frame (honoured only when idle)
//   s_data     : serial key / parity bit
//   s_valid    : s_data is valid
//   s_ready    : loader accepts a bit this cycle
//   zeroize    : clears the key and aborts any frame; error code is kept
//   key_out    : committed key; [3:0] -> p1..p4, [6:4] -> X_1..X_3
//   key_valid  : key_out holds a verified key
//   busy       : a frame is in progress
//   err_code   : last frame result: 00 ok/none, 01 parity fail, 10 timeout
// ---------------------------------------------------------------------------
module c432_key_loader #(
  parameter int KEY_W  = 7,
  parameter int TO_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             zeroize,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic [1:0]       err_code
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam int TO_W  = $clog2(TO_CYC + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [TO_W-1:0]  idle_cnt_q;
  logic [KEY_W-1:0] shadow_q;
  logic [KEY_W-1:0] key_q;
  logic             key_valid_q;
  logic [1:0]       err_q;

  logic accept;
  logic timeout_hit;
  logic parity_pass;

  // Even parity over the collected key plus the received parity bit.
  function automatic logic parity_ok(input logic [KEY_W-1:0] sh,
                                     input logic             pbit);
    return ~((^sh) ^ pbit);
  endfunction

  assign accept      = s_valid & s_ready;
  // Fires on the edge that would take the idle count to TO_CYC.
  assign timeout_hit = (state_q != ST_IDLE) && !accept && (idle_cnt_q == TO_LAST);
  assign parity_pass = parity_ok(shadow_q, s_data);

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    if (zeroize) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_start) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (accept && (bit_cnt_q == LAST_BIT)) state_d = ST_PARITY;
          else if (timeout_hit)                  state_d = ST_IDLE;
        end
        ST_PARITY: begin
          if (accept || timeout_hit) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---- output decode ----
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_SHIFT, ST_PARITY: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      default: begin
        s_ready = 1'b0;
        busy    = 1'b0;
      end
    endcase
  end

  // ---- frame collection: shadow register and counters ----
  // Shifting in at the MSB end leaves the first bit in shadow[0] after
  // KEY_W accepted bits. Counters are re-armed whenever a frame opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      shadow_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            shadow_q   <= '0;
          end
        end
        ST_SHIFT: begin
          if (accept) begin
            shadow_q   <= {s_data, shadow_q[KEY_W-1:1]};
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (accept) idle_cnt_q <= '0;
          else        idle_cnt_q <= idle_cnt_q + 1'b1;
        end
        default: begin
          idle_cnt_q <= '0;
        end
      endcase
    end
  end

  // ---- committed key and frame result ----
  // zeroize wins over a same-edge parity commit and a same-edge load_start,
  // but leaves the last error code visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= '0;
      key_valid_q <= 1'b0;
      err_q       <= ERR_NONE;
    end else if (zeroize) begin
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && load_start) begin
        err_q <= ERR_NONE;
      end
      if ((state_q == ST_PARITY) && accept) begin
        if (parity_pass) begin
          key_q       <= shadow_q;
          key_valid_q <= 1'b1;
        end else begin
          err_q <= ERR_PARITY;
        end
      end
      if (timeout_hit) begin
        err_q <= ERR_TIMEOUT;
      end
    end
  end

  assign key_out   = key_q;
  assign key_valid = key_valid_q;
  assign err_code  = err_q;

endmodule

// File: tb/tb_c432_key_loader.sv
// ---------------------------------------------------------------------------
// tb_c432_key_loader
//
// Directed bench for c432_key_loader. A frame-level reference model (bit list
// accumulated as an integer, parity by population count, idle-cycle count)
// advances on every rising edge; a compare process checks every DUT output
// against it on each falling edge. Literal expectations at key points pin the
// model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_c432_key_loader;

  localparam int KEY_W  = 7;
  localparam int TO_CYC = 16;

  logic             clk;
  logic             rst_n;
  logic             load_start;
  logic             s_data;
  logic             s_valid;
  logic             s_ready;
  logic             zeroize;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic [1:0]       err_code;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  // reference model
  int m_key    = 0;
  int m_kv     = 0;
  int m_active = 0;
  int m_err    = 0;
  int m_nbits  = 0;
  int m_sh     = 0;
  int m_idle   = 0;

  c432_key_loader #(.KEY_W(KEY_W), .TO_CYC(TO_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .zeroize    (zeroize),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .busy       (busy),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_key = 0; m_kv = 0; m_active = 0; m_err = 0;
    m_nbits = 0; m_sh = 0; m_idle = 0;
  endtask

  // One clock edge of frame-level behaviour, from the inputs seen on that edge.
  task automatic model_step(input logic ls, input logic v, input logic d, input logic z);
    int ones;
    if (z) begin
      m_key = 0; m_kv = 0; m_active = 0;
    end else if (m_active == 0) begin
      if (ls) begin
        m_active = 1; m_nbits = 0; m_sh = 0; m_idle = 0; m_err = 0;
      end
    end else if (v) begin
      m_idle = 0;
      if (m_nbits < KEY_W) begin
        m_sh = m_sh | (int'(d) << m_nbits);
        m_nbits++;
      end else begin
        ones = $countones(m_sh) + int'(d);
        if (ones % 2 == 0) begin
          m_key = m_sh; m_kv = 1;
        end else begin
          m_err = 1;
        end
        m_active = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == TO_CYC) begin
        m_err = 2; m_active = 0;
      end
    end
  endtask

  task automatic cyc(input logic ls, input logic v, input logic d, input logic z);
    load_start = ls; s_valid = v; s_data = d; zeroize = z;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(ls, v, d, z);
    #1;
    cyc_n++;
  endtask

  // Start cycle, then KEY_W key bits and the parity bit. gap inserts an
  // s_valid=0 cycle before every bit; ls_at raises load_start with that bit;
  // z_par raises zeroize with the parity bit.
  task automatic send_frame(input logic [KEY_W-1:0] k, input logic p,
                            input int gap, input int ls_at, input int z_par);
    logic b;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= KEY_W; i++) begin
      if (gap != 0) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (i < KEY_W) b = k[i];
      else           b = p;
      cyc(i == ls_at, 1'b1, b, (i == KEY_W) && (z_par != 0));
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("key_out",   32'(key_out),   m_key);
    chk("key_valid", 32'(key_valid), m_kv);
    chk("busy",      32'(busy),      m_active);
    chk("s_ready",   32'(s_ready),   m_active);
    chk("err_code",  32'(err_code),  m_err);
  end

  initial begin
    int t0;
    rst_n = 1'b0; load_start = 1'b0; s_valid = 1'b0; s_data = 1'b0; zeroize = 1'b0;

    // reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_key",  32'(key_out),  32'h0);
    chk("rst_busy", 32'(busy),     32'h0);
    chk("rst_rdy",  32'(s_ready),  32'h0);
    chk("rst_err",  32'(err_code), 32'h0);
    rst_n = 1'b1;

    // s_valid in IDLE is ignored
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("idle_busy", 32'(busy), 32'h0);

    // good load 0x53: bits 1,1,0,0,1,0,1 parity 0, 9 cycles
    t0 = cyc_n;
    send_frame(7'h53, 1'b0, 0, -1, 0);
    chk("good_len",   32'(cyc_n - t0),   32'd9);
    chk("good_key",   32'(key_out),      32'h53);
    chk("good_kv",    32'(key_valid),    32'h1);
    chk("good_p1_4",  32'(key_out[3:0]), 32'h3);
    chk("good_x1_3",  32'(key_out[6:4]), 32'h5);
    chk("good_err",   32'(err_code),     32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("good_busy_fall", 32'(busy), 32'h0);

    // parity fail: 0x2A needs parity 1, send 0
    send_frame(7'h2A, 1'b0, 0, -1, 0);
    chk("pfail_err", 32'(err_code),  32'h1);
    chk("pfail_key", 32'(key_out),   32'h53);
    chk("pfail_kv",  32'(key_valid), 32'h1);

    // timeout after 3 bits and 16 idle cycles
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("to_err_clr", 32'(err_code), 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (TO_CYC - 1) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_busy_15", 32'(busy), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_busy_16", 32'(busy),     32'h0);
    chk("to_err",     32'(err_code), 32'h2);
    chk("to_key",     32'(key_out),  32'h53);

    // back-to-back good frame 0x7F, parity 1
    send_frame(7'h7F, 1'b1, 0, -1, 0);
    chk("7f_key", 32'(key_out),  32'h7F);
    chk("7f_err", 32'(err_code), 32'h0);

    // sparse handshake: 0x53 with a gap before every bit -> 17 cycles
    t0 = cyc_n;
    send_frame(7'h53, 1'b0, 1, -1, 0);
    chk("sparse_len", 32'(cyc_n - t0), 32'd17);
    chk("sparse_key", 32'(key_out),    32'h53);

    // load_start during SHIFT is ignored; 0x2A with correct parity 1
    send_frame(7'h2A, 1'b1, 0, 3, 0);
    chk("ls_ign_key", 32'(key_out), 32'h2A);

    // zeroize on the same edge as a correct parity bit
    send_frame(7'h7F, 1'b1, 0, -1, 1);
    chk("zc_key",  32'(key_out),   32'h0);
    chk("zc_kv",   32'(key_valid), 32'h0);
    chk("zc_busy", 32'(busy),      32'h0);

    // zeroize beats load_start in IDLE
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("zls_busy", 32'(busy), 32'h0);

    // zeroize keeps the error code
    send_frame(7'h11, 1'b1, 0, -1, 0);
    chk("z_err_pre", 32'(err_code), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("z_err_keep", 32'(err_code), 32'h1);

    // reset mid-frame after 4 bits, asserted between edges
    send_frame(7'h53, 1'b0, 0, -1, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mr_key",  32'(key_out),   32'h0);
    chk("mr_kv",   32'(key_valid), 32'h0);
    chk("mr_busy", 32'(busy),      32'h0);
    chk("mr_rdy",  32'(s_ready),   32'h0);
    chk("mr_err",  32'(err_code),  32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;

    // 0x35 = 0110101, four ones -> parity 0
    send_frame(7'h35, 1'b0, 0, -1, 0);
    chk("post_rst_key", 32'(key_out),   32'h35);
    chk("post_rst_kv",  32'(key_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
